next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/next_pc_unit.sv
// Fetch PC sequencer for a MIPS-style core: sequential fetch, J/JR/branch/exception redirects,
// an optional branch delay slot, and a one-entry pending redirect buffer that survives stalls.
module next_pc_unit #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              j_valid,
    input  logic [ADDR_W-1:0] j_pc,
    input  logic [25:0]       j_index,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_off,
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              flush,
    output logic              pending,
    output logic              align_err
);

    localparam logic [ADDR_W-1:0] FOUR   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VECTOR[ADDR_W-1:0];

    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] req_tgt;
    logic              req_valid;
    logic [ADDR_W-1:0] pend_tgt;
    logic              pend_exc;

    assign pc_plus4 = pc + FOUR;

    // The jump region comes from the delay-slot address; a 28-bit PC has no region bits at all.
    generate
        if (ADDR_W > 28) begin : g_region
            logic [ADDR_W-1:0] j_pc4;
            assign j_pc4 = j_pc + FOUR;
            assign j_tgt = {j_pc4[ADDR_W-1:28], j_index, 2'b00};
        end else begin : g_noregion
            assign j_tgt = {j_index, 2'b00};
        end
    endgenerate

    assign jr_tgt = {jr_addr[ADDR_W-1:2], 2'b00};
    assign br_tgt = br_pc + FOUR + {{(ADDR_W-18){br_off[15]}}, br_off, 2'b00};

    always_comb begin
        req_valid = jr_valid | j_valid | br_taken;
        req_tgt   = br_tgt;
        if (jr_valid) begin
            req_tgt = jr_tgt;
        end else if (j_valid) begin
            req_tgt = j_tgt;
        end
    end

    // Exceptions beat everything; a buffered redirect beats fresh ones; stalls only fill the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RST_PC;
            pending   <= 1'b0;
            pend_tgt  <= '0;
            pend_exc  <= 1'b0;
            flush     <= 1'b0;
            align_err <= 1'b0;
        end else begin
            align_err <= jr_valid && (jr_addr[1:0] != 2'b00);
            flush     <= 1'b0;
            if (stall) begin
                if (exc_valid) begin
                    pending  <= 1'b1;
                    pend_tgt <= EXC_PC;
                    pend_exc <= 1'b1;
                end else if (req_valid && !pending) begin
                    pending  <= 1'b1;
                    pend_tgt <= req_tgt;
                    pend_exc <= 1'b0;
                end
            end else if (exc_valid) begin
                pc       <= EXC_PC;
                pending  <= 1'b0;
                pend_exc <= 1'b0;
                flush    <= 1'b1;
            end else if (pending) begin
                pc       <= pend_tgt;
                pending  <= 1'b0;
                pend_exc <= 1'b0;
                flush    <= pend_exc || !DELAY_SLOT;
            end else if (req_valid) begin
                if (DELAY_SLOT) begin
                    pc       <= pc_plus4;
                    pending  <= 1'b1;
                    pend_tgt <= req_tgt;
                    pend_exc <= 1'b0;
                end else begin
                    pc    <= req_tgt;
                    flush <= 1'b1;
                end
            end else begin
                pc <= pc_plus4;
            end
        end
    end

endmodule
